// File: rtl/fruit_spawner.sv
// fruit_spawner: owns the three fruit lanes. It advances each fruit's fall
// once per game tick and latches player slices. It reports alive/sliced
// flags and the chk sample strobe to the game control FSM.

// One fruit lane: IDLE / FALL / SLICED / LOST, with registered flags and position.
module fruit_lane #(
  parameter int FALL_STEPS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,     // lane enabled by current level
  input  logic       rise,   // respawn edge (already qualified by en)
  input  logic       tick,   // game tick cycle
  input  logic       hit,    // slice aimed at this lane
  input  logic       step2,  // fast fall (level >= 2)
  input  logic [2:0] xin,    // spawn column chosen for this respawn
  output logic       ac,
  output logic       d,
  output logic [3:0] y,
  output logic [2:0] x
);
  typedef enum logic [1:0] {IDLE, FALL, SLICED, LOST} st_t;
  st_t        st;
  logic [4:0] ny;

  assign ny = {1'b0, y} + (step2 ? 5'd2 : 5'd1);

  // Lane FSM. Priority is disable > respawn > slice > tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      ac <= 1'b0;
      d  <= 1'b0;
      y  <= '0;
      x  <= '0;
    end else if (!en) begin
      st <= IDLE;
      ac <= 1'b0;
      d  <= 1'b0;
    end else if (rise) begin
      st <= FALL;
      ac <= 1'b1;
      d  <= 1'b0;
      y  <= '0;
      x  <= xin;
    end else if (st == FALL) begin
      if (hit) begin
        st <= SLICED;
        d  <= 1'b1;
      end else if (tick) begin
        if (ny >= 5'(FALL_STEPS)) begin
          st <= LOST;
          ac <= 1'b0;
          y  <= 4'(FALL_STEPS - 1);
        end else begin
          y  <= ny[3:0];
        end
      end
    end
  end
endmodule

module fruit_spawner #(
  parameter int         TICK_DIV   = 1_000_000,
  parameter int         FALL_STEPS = 16,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] level,
  input  logic       rs1,
  input  logic       rs2,
  input  logic       rs3,
  input  logic       slice,
  input  logic [1:0] blade_lane,
  output logic       chk,
  output logic       ac1,
  output logic       ac2,
  output logic       ac3,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic [3:0] y1,
  output logic [3:0] y2,
  output logic [3:0] y3,
  output logic [2:0] x1,
  output logic [2:0] x2,
  output logic [2:0] x3
);
  localparam int NUM_LANES = 3;
  localparam int CW        = $clog2(TICK_DIV);

  logic [CW-1:0]                  cnt;
  logic                           tick;
  logic [7:0]                     lfsr;
  logic [NUM_LANES-1:0]           rs_v, rs_q, en, rise, hit;
  logic [NUM_LANES:0][7:0]        lchain;
  logic [NUM_LANES-1:0][2:0]      xsel, x_v;
  logic [NUM_LANES-1:0][3:0]      y_v;
  logic [NUM_LANES-1:0]           ac_v, d_v;

  // x^8+x^6+x^5+x^4+1 Fibonacci, shifting left.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  assign tick = (cnt == CW'(TICK_DIV - 1));
  assign rs_v = {rs3, rs2, rs1};
  assign en   = {level[1], level != 2'd0, 1'b1};
  assign rise = rs_v & ~rs_q & en;

  // Same-cycle respawns consume consecutive LFSR states in lane order.
  always_comb begin
    lchain[0] = lfsr;
    xsel      = '0;
    hit       = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      xsel[i]     = (lchain[i][2:0] >= 3'd6) ? lchain[i][2:0] - 3'd6 : lchain[i][2:0];
      lchain[i+1] = rise[i] ? lfsr_step(lchain[i]) : lchain[i];
      hit[i]      = slice && (blade_lane == 2'(i + 1));
    end
  end

  // Tick divider, chk strobe one cycle after the tick cycle, LFSR and rs edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      chk  <= 1'b0;
      lfsr <= LFSR_SEED;
      rs_q <= '0;
    end else begin
      cnt  <= tick ? '0 : cnt + 1'b1;
      chk  <= tick;
      lfsr <= lchain[NUM_LANES];
      rs_q <= rs_v;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fruit_lane #(.FALL_STEPS(FALL_STEPS)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (en[g]),
      .rise  (rise[g]),
      .tick  (tick),
      .hit   (hit[g]),
      .step2 (level[1]),
      .xin   (xsel[g]),
      .ac    (ac_v[g]),
      .d     (d_v[g]),
      .y     (y_v[g]),
      .x     (x_v[g])
    );
  end

  assign {ac3, ac2, ac1} = ac_v;
  assign {d3, d2, d1}    = d_v;
  assign y1 = y_v[0];
  assign y2 = y_v[1];
  assign y3 = y_v[2];
  assign x1 = x_v[0];
  assign x2 = x_v[1];
  assign x3 = x_v[2];
endmodule

// File: tb/tb_fruit_spawner.sv
// Randomized + directed bench for fruit_spawner against a behavioural lane model.
module tb_fruit_spawner;
  localparam int TD = 4;
  localparam int FS = 8;
  localparam int S_IDLE = 0, S_FALL = 1, S_SLC = 2, S_LOST = 3;

  logic       clk = 1'b0;
  logic       rst, rs1, rs2, rs3, slice;
  logic [1:0] level, blade_lane;
  logic       chk, ac1, ac2, ac3, d1, d2, d3;
  logic [3:0] y1, y2, y3;
  logic [2:0] x1, x2, x3;

  always #5 clk = ~clk;

  fruit_spawner #(.TICK_DIV(TD), .FALL_STEPS(FS), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .level(level), .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .slice(slice), .blade_lane(blade_lane), .chk(chk),
    .ac1(ac1), .ac2(ac2), .ac3(ac3), .d1(d1), .d2(d2), .d3(d3),
    .y1(y1), .y2(y2), .y3(y3), .x1(x1), .x2(x2), .x3(x3)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: game-level view of each lane's fruit.
  int m_cnt, m_chk, m_lfsr;
  int m_st[3], m_y[3], m_x[3];
  bit m_rsp[3];

  function automatic int lfsr_next(input int s);
    int fb;
    fb = ((s >> 7) + (s >> 5) + (s >> 4) + (s >> 3)) % 2;
    return ((s * 2) + fb) % 256;
  endfunction

  task automatic model_edge();
    bit rs[3];
    bit tk;
    int nen, step, l, ny;
    rs[0] = rs1; rs[1] = rs2; rs[2] = rs3;
    if (rst) begin
      m_cnt = 0; m_chk = 0; m_lfsr = 8'hA5;
      for (int i = 0; i < 3; i++) begin
        m_st[i] = S_IDLE; m_y[i] = 0; m_x[i] = 0; m_rsp[i] = 0;
      end
      return;
    end
    tk    = (m_cnt == TD - 1);
    m_cnt = (m_cnt + 1) % TD;
    m_chk = tk;
    nen   = (level == 0) ? 1 : (level == 1) ? 2 : 3;
    step  = (level >= 2) ? 2 : 1;
    l     = m_lfsr;
    for (int i = 0; i < 3; i++) begin
      if (i >= nen) m_st[i] = S_IDLE;
      else if (rs[i] && !m_rsp[i]) begin
        m_st[i] = S_FALL; m_y[i] = 0; m_x[i] = (l % 8) % 6;
        l = lfsr_next(l);
      end else if (m_st[i] == S_FALL && slice && blade_lane == i + 1) m_st[i] = S_SLC;
      else if (m_st[i] == S_FALL && tk) begin
        ny = m_y[i] + step;
        if (ny >= FS) begin m_y[i] = FS - 1; m_st[i] = S_LOST; end
        else m_y[i] = ny;
      end
      m_rsp[i] = rs[i];
    end
    m_lfsr = l;
  endtask

  // One clock: advance the model with the current inputs, then compare every output.
  task automatic cyc();
    int a[3], dd[3], yy[3], xx[3];
    model_edge();
    @(posedge clk);
    #1;
    a  = '{int'(ac1), int'(ac2), int'(ac3)};
    dd = '{int'(d1), int'(d2), int'(d3)};
    yy = '{int'(y1), int'(y2), int'(y3)};
    xx = '{int'(x1), int'(x2), int'(x3)};
    check_eq("chk", chk, m_chk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("ac%0d", i + 1), a[i], int'(m_st[i] == S_FALL || m_st[i] == S_SLC));
      check_eq($sformatf("d%0d", i + 1), dd[i], int'(m_st[i] == S_SLC));
      check_eq($sformatf("y%0d", i + 1), yy[i], m_y[i]);
      check_eq($sformatf("x%0d", i + 1), xx[i], m_x[i]);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_rs(input bit a, input bit b, input bit c);
    rs1 = a; rs2 = b; rs3 = c;
    cyc();
    rs1 = 0; rs2 = 0; rs3 = 0;
  endtask

  task automatic do_reset();
    rst = 1; cyc(); cyc(); rst = 0;
  endtask

  initial begin
    int k;
    rst = 1; rs1 = 0; rs2 = 0; rs3 = 0; slice = 0; level = 0; blade_lane = 0;
    do_reset();
    check_eq("rst_chk", chk, 0);
    check_eq("rst_ac1", ac1, 0);

    // Free run: first chk four cycles after reset release.
    run(3);
    check_eq("chk_c3", chk, 0);
    cyc();
    check_eq("chk_c4", chk, 1);
    run(8);

    // Level 0 spawn, fall to the bottom unsliced.
    pulse_rs(1, 0, 0);
    check_eq("spawn_ac1", ac1, 1);
    check_eq("spawn_y1", y1, 0);
    check_eq("spawn_x1", x1, 5);
    run(40);
    check_eq("lost_ac1", ac1, 0);
    check_eq("lost_y1", y1, 7);

    // Slice at y1=3, then frozen; wrong-lane slice ignored.
    pulse_rs(1, 0, 0);
    k = 0;
    while (m_y[0] != 3 && k < 40) begin cyc(); k++; end
    if (k >= 40) check_eq("timeout_y3", 0, 1);
    slice = 1; blade_lane = 1; cyc(); slice = 0;
    check_eq("slc_d1", d1, 1);
    run(20);
    check_eq("slc_y1", y1, 3);
    check_eq("slc_ac1", ac1, 1);
    slice = 1; blade_lane = 2; cyc(); slice = 0;

    // Level 2: simultaneous respawn walks the LFSR from the seed.
    do_reset();
    level = 2;
    pulse_rs(1, 1, 1);
    check_eq("tri_x1", x1, 5);
    check_eq("tri_x2", x2, 2);
    check_eq("tri_x3", x3, 5);
    run(20);

    // Slice and bottom-crossing tick together at y1=7.
    level = 0;
    pulse_rs(1, 0, 0);
    k = 0;
    while (!(m_y[0] == 7 && m_st[0] == S_FALL && m_cnt == TD - 1) && k < 60) begin cyc(); k++; end
    if (k >= 60) check_eq("timeout_y7", 0, 1);
    slice = 1; blade_lane = 1; cyc(); slice = 0;
    check_eq("edge_ac1", ac1, 1);
    check_eq("edge_d1", d1, 1);
    check_eq("edge_y1", y1, 7);
    slice = 1; rs1 = 1; cyc(); slice = 0; rs1 = 0;
    check_eq("rsslc_d1", d1, 0);
    check_eq("rsslc_y1", y1, 0);
    run(6);

    // Level 1: lane 3 stays idle; mid-fall reset restores the seed.
    level = 1;
    pulse_rs(1, 1, 1);
    run(3);
    check_eq("l1_ac3", ac3, 0);
    rst = 1; cyc(); rst = 0;
    check_eq("mr_ac1", ac1, 0);
    check_eq("mr_y1", y1, 0);
    check_eq("mr_x1", x1, 0);
    level = 0;
    pulse_rs(1, 0, 0);
    check_eq("mr_seed_x1", x1, 5);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) level = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) rs1 = ~rs1;
      if ($urandom_range(0, 9) == 0) rs2 = ~rs2;
      if ($urandom_range(0, 9) == 0) rs3 = ~rs3;
      slice      = ($urandom_range(0, 5) == 0);
      blade_lane = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fruit_spawner.md
Name: fruit_spawner

Overview:
- Lane-side counterpart of the game control FSM: it owns the three fruit lanes, advances each fruit's fall, and latches player slices.
- It returns per-lane alive (ac1..ac3) and sliced (d1..d3) flags plus the chk sample strobe to the control FSM.
- It consumes the control FSM's respawn requests (rs1..rs3) and level.
- It also drives fruit coordinates to the display renderer.

Parameters:
- TICK_DIV, 1_000_000: clk cycles per game tick (chk period); minimum 4.
- FALL_STEPS, 16: vertical positions per lane; a fruit at y >= FALL_STEPS is lost; power of two, max 16.
- LFSR_SEED, 8'hA5: reset value of the 8-bit spawn-column LFSR; must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- level  in  2  current level from control FSM
- rs1, rs2, rs3  in  1 each  respawn request per lane; action on rising edge
- slice  in  1  player slice strobe, one clk cycle
- blade_lane  in  2  lane under blade: 1..3 valid; 0 = none
- chk  out  1  one-cycle sample strobe per game tick
- ac1, ac2, ac3  out  1 each  fruit alive in lane (not lost)
- d1, d2, d3  out  1 each  fruit in lane has been sliced
- y1, y2, y3  out  4 each  fruit vertical position
- x1, x2, x3  out  3 each  fruit spawn column

Behaviour:
- Reset (rst=1 at posedge clk): chk=0, all ac/d=0, all y=0, all x=0, tick counter=0, LFSR=LFSR_SEED, rs edge registers=0, all lanes IDLE.
- Tick counter: counts 0..TICK_DIV-1 and wraps. The cycle it reaches TICK_DIV-1 is the tick cycle. chk=1 in the cycle after the tick cycle, high for exactly one cycle. ac/d/y updated by a tick are therefore stable while chk=1.
- Lane enable from level:
  - level 0: lane 1 only.
  - level 1: lanes 1–2.
  - level 2 or 3: all three lanes.
  - A disabled lane stays IDLE: ignores rs and slice, holds ac=0, d=0.
- Per-lane state machine, states IDLE, FALL, SLICED, LOST:
  - IDLE: ac=0, d=0. Respawn -> FALL.
  - FALL: ac=1, d=0. On each tick y += step, where step=1 at level 0/1 and step=2 at level >=2.
    - If y+step >= FALL_STEPS: y saturates at FALL_STEPS-1 and state -> LOST.
    - Slice with blade_lane == lane index -> SLICED; y frozen.
  - SLICED: ac=1, d=1; y frozen. Respawn -> FALL.
  - LOST: ac=0, d=0. Respawn -> FALL.
- Respawn: rising edge of rsN, detected as rsN=1 with previous rsN=0, on an enabled lane.
  - Sets y=0, ac=1, d=0, state FALL.
  - Sets xN = LFSR[2:0] mod 6 (range 0..5).
  - LFSR (x^8+x^6+x^5+x^4+1, Fibonacci) steps once for each respawn.
  - Simultaneous respawns in one cycle are served in lane order 1,2,3, each lane taking the next LFSR state (LFSR advances up to 3 steps that cycle).
  - Falling edges of rs and a held-high rs: no action.
- Simultaneous events, same lane, same cycle:
  - Respawn beats slice and tick.
  - Slice beats the tick's bottom crossing: the lane ends SLICED with y unchanged.
- Slice when state is not FALL, or when blade_lane=0: ignored.
- A slice arriving while chk=1 takes effect in the next cycle; the control FSM sees it on the following chk.
- Level change mid-fall:
  - Newly disabled lanes go IDLE immediately.
  - Newly enabled lanes stay IDLE until their rs rising edge.
  - Step size changes take effect on the next tick.
- Reset mid-operation: everything returns to reset values on the next clk edge regardless of state; no chk pulse in that cycle.
- Power-up handshake: after reset lane 1 reports ac1=0. The control FSM then raises rs1, which spawns the first fruit.

Test Plan (TICK_DIV=4, FALL_STEPS=8):
- Reset then free run -> chk high 1 cycle every 4 cycles, first chk at cycle 4 after reset release; ac1..ac3=0; x all 0.
- level=0, pulse rs1 -> ac1=1, d1=0, y1=0 next cycle. No slice: y1 reaches 7 after 7 ticks; the 8th tick sets ac1=0 (LOST) before that chk.
- level=0, fruit falling at y1=3, slice with blade_lane=1 -> d1=1, ac1=1, y1 stays 3 across 5 further ticks. Slice with blade_lane=2 -> no change.
- level=2, raise rs1, rs2, rs3 in the same cycle -> all three FALL with y=0; x1, x2, x3 taken from three consecutive LFSR states starting at seed 8'hA5. Each subsequent tick adds 2 to y.
- Slice and bottom-crossing tick in the same cycle at y1=7 -> lane ends SLICED (ac1=1, d1=1, y1=7). rs1 rise plus slice in the same cycle -> FALL, d1=0, y1=0.
- level=1 with lane 3 driven by rs3 -> ac3 stays 0. Assert rst mid-fall -> all outputs 0 and LFSR back to 8'hA5 one cycle later.
